instr_fetch_queue: RTL and testbench

//  Prefetching fetch front-end directly upstream of the IF stage of the 5-stage MIPS pipeline.

---
 rtl/ifq_pkg.sv | 12 +
 rtl/ifq_fifo.sv | 61 ++++++
 rtl/instr_fetch_queue.sv | 142 ++++++++++++++
 tb/tb_instr_fetch_queue.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// Shared definitions for the instruction fetch queue.
// State encoding, PC increment and instruction constants.
package ifq_pkg;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam int PC_INC  = 4;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP = 32'h0;
endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO of {pc, instr} pairs with clear, push, pop and occupancy.
// Push is accepted when full only if a pop frees a slot in the same cycle.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               push,
    input  logic [PC_W-1:0]    push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic               pop,
    output logic [PC_W-1:0]    head_pc,
    output logic [INSTR_W-1:0] head_instr,
    output logic [CW-1:0]      count,
    output logic               empty
);
    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               full;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

    // Storage needs no reset: reads are masked by the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
        end
    end
endmodule

// File: rtl/instr_fetch_queue.sv
// Prefetching fetch front-end: issues sequential fetches, buffers responses.
// Optional IFQ_PERF_CNT_EN adds saturating drop / starvation counters.
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int DEPTH               = 4,
    parameter int MAX_OUTST           = 4,
    parameter int ADDR_W              = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [ADDR_W-1:0]  req_addr,
    input  logic               resp_valid,
    input  logic [INSTR_W-1:0] resp_data,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               out_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [31:0]        perf_dropped,
    output logic [31:0]        perf_starve
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]        state;
    logic [1:0]        state_n;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [ADDR_W-1:0] target;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     outst_n;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     drop_n;
    logic [CW-1:0]     occupancy;
    logic [CW:0]       credit_used;
    logic              hs;
    logic              stale;
    logic              push;
    logic              pop;
    logic              empty;
    logic [ADDR_W-1:0]  head_pc;
    logic [INSTR_W-1:0] head_instr;
    logic              unused_lsb;

    assign unused_lsb = ^redirect_pc[1:0];
    assign target     = {redirect_pc[ADDR_W-1:2], 2'b00};

    // Queued plus in-flight entries may never exceed storage.
    assign credit_used = {1'b0, occupancy} + {1'b0, outstanding};
    assign req_valid   = (state == S_FETCH) & en & ~redirect
                       & (credit_used < (CW+1)'(DEPTH))
                       & (outstanding < CW'(MAX_OUTST));
    assign req_addr    = fetch_pc;
    assign hs          = req_valid & req_ready;

    assign stale = (drop_cnt != '0);
    assign push  = resp_valid & ~stale & ~redirect;
    assign pop   = out_valid & out_ready & ~redirect;

    assign out_valid = ~empty;
    assign out_pc    = out_valid ? head_pc : '0;
    assign out_instr = out_valid ? head_instr : NOP;

    always_comb begin
        drop_n  = drop_cnt - CW'(resp_valid & stale);
        outst_n = outstanding + CW'(hs) - CW'(resp_valid & ~stale);
        if (redirect) begin
            drop_n  = drop_cnt + outstanding - CW'(resp_valid);
            outst_n = '0;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (en && !redirect) state_n = S_FETCH;
            S_FETCH: if (redirect && drop_n != '0) state_n = S_FLUSH;
            S_FLUSH: if (drop_n == '0) state_n = S_FETCH;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_n;
            outstanding <= outst_n;
            drop_cnt    <= drop_n;
            if (redirect) begin
                fetch_pc <= target;
                resp_pc  <= target;
            end else begin
                if (hs)   fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
                if (push) resp_pc  <= resp_pc + ADDR_W'(PC_INC);
            end
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH),
        .PC_W  (ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (redirect),
        .push       (push),
        .push_pc    (resp_pc),
        .push_instr (resp_data),
        .pop        (pop),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .count      (occupancy),
        .empty      (empty)
    );

`ifdef IFQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_dropped <= '0;
            perf_starve  <= '0;
        end else begin
            if (resp_valid && (stale || redirect) && perf_dropped != '1)
                perf_dropped <= perf_dropped + 32'd1;
            if (out_ready && !out_valid && perf_starve != '1)
                perf_starve <= perf_starve + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a fixed-latency in-order memory.
// Build with IFQ_PERF_CNT_EN defined to also check the drop counter.
module tb_instr_fetch_queue;
    logic        clk;
    logic        reset;
    logic        en;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef IFQ_PERF_CNT_EN
    logic [31:0] perf_dropped;
    logic [31:0] perf_starve;
`endif

    instr_fetch_queue dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_ready   (out_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef IFQ_PERF_CNT_EN
        ,
        .perf_dropped (perf_dropped),
        .perf_starve  (perf_starve)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t mq[$];
    int    cyc;
    int    lat;
    int    hs_cnt;
    int    checks;
    int    failures;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes, advance, then present the memory response.
    task automatic tick();
        logic        hs;
        logic        rv;
        logic        rst;
        logic [31:0] a;
        #1;
        hs  = req_valid & req_ready;
        a   = req_addr;
        rv  = resp_valid;
        rst = reset;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            mq.delete();
        end else begin
            if (rv && mq.size() > 0) mq.delete(0);
            if (hs) begin
                mq.push_back('{a, cyc + lat - 1});
                hs_cnt++;
            end
        end
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            resp_valid = 1'b1;
            resp_data  = ~mq[0].addr;
        end else begin
            resp_valid = 1'b0;
            resp_data  = '0;
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        en       = 1'b0;
        redirect = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        reset  = 1'b0;
        hs_cnt = 0;
        settle();
    endtask

    task automatic wait_out(input string tag, input int max);
        int n;
        n = 0;
        while (!out_valid && n < max) begin
            tick();
            settle();
            n++;
        end
        chk(tag, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        cyc         = 0;
        hs_cnt      = 0;
        lat         = 1;
        reset       = 1'b1;
        en          = 1'b0;
        req_ready   = 1'b1;
        resp_valid  = 1'b0;
        resp_data   = '0;
        out_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        // Sequential stream with a 1-cycle memory
        do_reset();
        chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        en = 1'b1;
        settle();
        chk("idle_no_req", {31'd0, req_valid}, 32'd0);
        tick(); settle();
        chk("t1_req0_valid", {31'd0, req_valid}, 32'd1);
        chk("t1_req0_addr", req_addr, 32'h0);
        tick(); settle();
        chk("t1_req1_addr", req_addr, 32'h4);
        chk("t1_not_yet_valid", {31'd0, out_valid}, 32'd0);
        tick(); settle();
        chk("t1_out_valid_lat", {31'd0, out_valid}, 32'd1);
        chk("t1_out_pc0", out_pc, 32'h0);
        chk("t1_out_instr0", out_instr, 32'hFFFF_FFFF);
        chk("t1_req2_addr", req_addr, 32'h8);
        out_ready = 1'b1;
        tick(); settle();
        chk("t1_out_pc4", out_pc, 32'h4);
        chk("t1_req3_addr", req_addr, 32'hC);
        tick(); settle();
        chk("t1_out_pc8", out_pc, 32'h8);

        // Back-pressure: credits limit issue to DEPTH
        do_reset();
        lat = 1;
        en  = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        settle();
        chk("t2_hs_count", hs_cnt, 32'd4);
        chk("t2_req_blocked", {31'd0, req_valid}, 32'd0);
        chk("t2_head_pc0", out_pc, 32'h0);
        out_ready = 1'b1;
        tick(); settle();
        chk("t2_drain_pc4", out_pc, 32'h4);
        chk("t2_resume_valid", {31'd0, req_valid}, 32'd1);
        chk("t2_resume_addr", req_addr, 32'h10);
        tick(); settle();
        chk("t2_drain_pc8", out_pc, 32'h8);
        tick(); settle();
        chk("t2_drain_pc12", out_pc, 32'hC);

        // Redirect with 3 requests in flight at latency 3
        lat = 3;
        do_reset();
        en = 1'b1;
        out_ready = 1'b1;
        tick(); tick(); tick(); tick(); settle();
        chk("t3_outstanding", hs_cnt, 32'd3);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        settle();
        chk("t3_redir_no_req", {31'd0, req_valid}, 32'd0);
        tick();
        redirect = 1'b0;
        settle();
        chk("t3_flush_no_req", {31'd0, req_valid}, 32'd0);
        chk("t3_flush_empty", {31'd0, out_valid}, 32'd0);
        wait_out("t3_wait_out", 30);
        chk("t3_first_pc", out_pc, 32'h100);
        chk("t3_first_instr", out_instr, ~32'h100);
`ifdef IFQ_PERF_CNT_EN
        chk("t3_perf_dropped", perf_dropped, 32'd3);
`endif

        // Redirect coinciding with a response and a pop; low PC bits ignored
        lat = 1;
        do_reset();
        en = 1'b1;
        out_ready = 1'b1;
        tick(); tick(); tick(); settle();
        chk("t4_pre_valid", {31'd0, out_valid}, 32'd1);
        chk("t4_pre_resp", {31'd0, resp_valid}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h302;
        settle();
        chk("t4_redir_no_req", {31'd0, req_valid}, 32'd0);
        tick();
        redirect = 1'b0;
        settle();
        chk("t4_empty_after", {31'd0, out_valid}, 32'd0);
        chk("t4_req_valid", {31'd0, req_valid}, 32'd1);
        chk("t4_req_addr", req_addr, 32'h300);
        wait_out("t4_wait_out", 10);
        chk("t4_first_pc", out_pc, 32'h300);
`ifdef IFQ_PERF_CNT_EN
        chk("t4_perf_dropped", perf_dropped, 32'd1);
`endif

        // Second redirect while still flushing
        lat = 3;
        do_reset();
        en = 1'b1;
        out_ready = 1'b1;
        tick(); tick(); tick(); settle();
        redirect    = 1'b1;
        redirect_pc = 32'h180;
        tick();
        redirect_pc = 32'h200;
        settle();
        chk("t5_flush_no_req", {31'd0, req_valid}, 32'd0);
        chk("t5_flush_empty", {31'd0, out_valid}, 32'd0);
        tick();
        redirect = 1'b0;
        settle();
        chk("t5_still_flush", {31'd0, req_valid}, 32'd0);
        wait_out("t5_wait_out", 30);
        chk("t5_first_pc", out_pc, 32'h200);
`ifdef IFQ_PERF_CNT_EN
        chk("t5_perf_dropped", perf_dropped, 32'd2);
`endif

        // Address wrap and enable freeze
        lat = 1;
        do_reset();
        en          = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        settle();
        chk("t6_idle_redir", {31'd0, req_valid}, 32'd0);
        tick();
        redirect = 1'b0;
        settle();
        chk("t6_idle_stay", {31'd0, req_valid}, 32'd0);
        tick(); settle();
        chk("t6_req_top", req_addr, 32'hFFFF_FFFC);
        tick(); settle();
        chk("t6_req_wrap", req_addr, 32'h0);
        tick();
        en = 1'b0;
        settle();
        chk("t6_en_freeze", {31'd0, req_valid}, 32'd0);
        chk("t6_out_top", out_pc, 32'hFFFF_FFFC);
        out_ready = 1'b1;
        tick(); settle();
        chk("t6_inflight_valid", {31'd0, out_valid}, 32'd1);
        chk("t6_inflight_pc", out_pc, 32'h0);
        chk("t6_inflight_instr", out_instr, 32'hFFFF_FFFF);
        tick(); settle();
        chk("t6_drained", {31'd0, out_valid}, 32'd0);
        chk("t6_still_frozen", {31'd0, req_valid}, 32'd0);

        // Reset in the middle of traffic
        lat = 3;
        en  = 1'b1;
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk("t7_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t7_rst_req_valid", {31'd0, req_valid}, 32'd0);
        chk("t7_rst_out_pc", out_pc, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
